decoder_scoreboard: RTL

- Parametrised register-file write-enable decoder plus pending-write scoreboard.
- Decodes an AW-bit commit address into 2**AW one-hot registered write enables.
- Tracks which registers have an issued-but-uncommitted write, and raises stall on RAW/WAW hazards against that set.
- Sits between issue logic and the register file of the pipelined CPU datapath.

---
 rtl/decoder_scoreboard.sv | 85 ++++++++
 1 files changed

// File: rtl/decoder_scoreboard.sv
// Register-file write-enable decoder and pending-write scoreboard.
// Flags RAW/WAW hazards against issued-but-uncommitted destinations; a commit in the same cycle clears its register first.

module dec1to2 (
  input  logic       en,
  input  logic       sel,
  output logic [1:0] y
);
  assign y[0] = en & ~sel;
  assign y[1] = en & sel;
endmodule

module decoder_scoreboard #(
  parameter int AW    = 4,
  parameter int NREAD = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_addr,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  input  logic                  commit_en,
  input  logic [AW-1:0]         commit_addr,
  output logic [(2**AW)-1:0]    wen,
  output logic [(2**AW)-1:0]    pending,
  output logic                  stall,
  output logic                  issue_ack,
  output logic                  err
);
  localparam int NREG = 2**AW;

  // Binary tree of 1-to-2 stages in heap order: node n feeds nodes 2n+1 and 2n+2,
  // so the leaves at NREG-1 .. 2*NREG-2 come out in address order.
  logic [2*NREG-2:0] tree;
  logic [NREG-1:0]   dec;

  assign tree[0] = commit_en;

  for (genvar n = 0; n < NREG-1; n++) begin : g_node
    localparam int LVL = $clog2(n+2) - 1;
    dec1to2 u_stage (
      .en  (tree[n]),
      .sel (commit_addr[AW-1-LVL]),
      .y   (tree[2*n+2:2*n+1])
    );
  end

  assign dec = tree[2*NREG-2:NREG-1];

  logic [NREG-1:0] eff;
  logic [NREG-1:0] pending_nxt;

  always_comb begin
    eff = pending;
    if (commit_en) eff[commit_addr] = 1'b0;
  end

  always_comb begin
    stall = issue_en & eff[issue_addr];
    for (int k = 0; k < NREAD; k++) begin
      if (rd_en[k] && eff[rd_addr[k*AW +: AW]]) stall = 1'b1;
    end
  end

  assign issue_ack = issue_en & ~stall;

  // Set is applied after the clear so an issue wins over a same-register commit.
  always_comb begin
    pending_nxt = eff;
    if (issue_ack) pending_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wen     <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      wen     <= dec;
      pending <= pending_nxt;
      err     <= err | (commit_en & ~pending[commit_addr]);
    end
  end
endmodule
